coriolis_stream_sink: RTL and testbench

CORIOLIS_STREAM_SINK -- requirements
Module: coriolis_stream_sink

---
 rtl/coriolis_pkg.sv | 35 +++
 rtl/coriolis_sync_fifo.sv | 56 +++++
 rtl/coriolis_stream_sink.sv | 102 ++++++++++
 tb/tb_coriolis_stream_sink.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coriolis_pkg.sv
// Shared definitions for the coriolis stream blocks: FloPoCo exception
// encodings, the canonical NaN, sink FSM states and the format converter.
package coriolis_pkg;

    // FloPoCo 2-bit exception field carried above the IEEE-754 word.
    typedef enum logic [1:0] {
        ExnZero   = 2'b00,
        ExnNormal = 2'b01,
        ExnInf    = 2'b10,
        ExnNan    = 2'b11
    } flopoco_exn_e;

    localparam logic [31:0] CanonicalNan = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } sink_state_e;

    // FloPoCo {exn, sign, exp, mant} to IEEE-754 single. The exception
    // field overrides whatever the exponent/mantissa bits hold.
    function automatic logic [31:0] flopoco_to_ieee(input logic [33:0] fp);
        logic [31:0] res;
        res = CanonicalNan;
        case (fp[33:32])
            ExnZero:   res = {fp[31], 31'b0};
            ExnNormal: res = fp[31:0];
            ExnInf:    res = {fp[31], 8'hFF, 23'b0};
            default:   res = CanonicalNan;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/coriolis_sync_fifo.sv
// Show-ahead synchronous FIFO: rdata is the head entry whenever !empty.
module coriolis_sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    // Qualify requests so a misbehaving caller cannot corrupt occupancy.
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        empty   = (count_q == '0);
        full    = (count_q == (AW+1)'(DEPTH));
        rdata   = mem_q[rptr_q];
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; empty/full gate every observable use of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/coriolis_stream_sink.sv
// Stream sink: accepts nitems FloPoCo results from a leaf node, buffers them
// and hands IEEE-754 singles to the memory writer, flagging done at the end.
module coriolis_stream_sink
    import coriolis_pkg::*;
#(
    parameter int unsigned STREAMW = 34,
    // Power of two, at least the upstream leaf latency + 1.
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNTW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNTW-1:0]    nitems,
    input  logic               ivalid,
    input  logic [STREAMW-1:0] idata,
    output logic               iready,
    output logic               ovalid,
    output logic [31:0]        odata,
    input  logic               oready,
    output logic               done
);

    sink_state_e        state_q;
    logic [CNTW-1:0]    nitems_q;
    logic [CNTW-1:0]    pushed_q;
    logic [CNTW-1:0]    popped_q;
    logic               done_q;
    logic               fifo_empty;
    logic               fifo_full;
    logic [STREAMW-1:0] fifo_head;
    logic               push;
    logic               pop;

    // Handshakes and outputs, derived only from registered state.
    always_comb begin
        iready = (state_q == StRun) & ~fifo_full & (pushed_q < nitems_q);
        ovalid = ~fifo_empty;
        // Convert on the read side; the head is stable while stalled.
        odata  = fifo_empty ? 32'h0 : flopoco_to_ieee(fifo_head[33:0]);
        push   = ivalid & iready;
        pop    = ovalid & oready;
        done   = done_q;
    end

    coriolis_sync_fifo #(
        .WIDTH (STREAMW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (idata),
        .pop   (pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Run-control FSM with item counters and the registered done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            nitems_q <= '0;
            pushed_q <= '0;
            popped_q <= '0;
            done_q   <= 1'b0;
        end else begin
            if (push) pushed_q <= pushed_q + CNTW'(1);
            if (pop)  popped_q <= popped_q + CNTW'(1);
            unique case (state_q)
                StIdle, StDone: begin
                    // FIFO is empty here, so clearing the counters loses nothing.
                    if (start) begin
                        nitems_q <= nitems;
                        pushed_q <= '0;
                        popped_q <= '0;
                        if (nitems != '0) begin
                            state_q <= StRun;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // start is ignored while a run is in flight.
                    if (pop && (popped_q + CNTW'(1) == nitems_q)) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coriolis_stream_sink.sv
// Scoreboard bench for coriolis_stream_sink: directed scenarios plus
// randomized runs checked against a count/queue level reference model.
module tb_coriolis_stream_sink;
    import coriolis_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] nitems;
    logic        ivalid;
    logic [33:0] idata;
    logic        iready;
    logic        ovalid;
    logic [31:0] odata;
    logic        oready;
    logic        done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        mon_en   = 1'b0;

    // Reference model state.
    logic [31:0] exp_q[$];
    logic        active     = 1'b0;
    logic [31:0] nitems_m   = 0;
    int unsigned pushed_cnt = 0;
    int unsigned pops_total = 0;
    int unsigned pop_base   = 0;

    coriolis_stream_sink #(
        .STREAMW (34),
        .DEPTH   (DEPTH),
        .CNTW    (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .nitems (nitems),
        .ivalid (ivalid),
        .idata  (idata),
        .iready (iready),
        .ovalid (ovalid),
        .odata  (odata),
        .oready (oready),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Conversion straight from the exception-field rules.
    function automatic logic [31:0] ref_conv(input logic [33:0] w);
        if (w[33:32] == 2'b00) return {w[31], 31'b0};
        if (w[33:32] == 2'b01) return w[31:0];
        if (w[33:32] == 2'b10) return {w[31], 8'hFF, 23'b0};
        return 32'h7FC0_0000;
    endfunction

    function automatic logic [33:0] rand_word();
        logic [33:0] w;
        w[33:32] = 2'($urandom_range(0, 3));
        w[31:0]  = $urandom();
        return w;
    endfunction

    // Input side: checks iready/done against the model, records accepted words.
    always @(negedge clk) begin
        int unsigned popped;
        int unsigned occ;
        if (mon_en) begin
            popped = pops_total - pop_base;
            occ    = pushed_cnt - popped;
            check("iready", iready, active && (pushed_cnt < nitems_m) && (occ < DEPTH));
            check("done", done, active && (popped == nitems_m));
            if (rst) begin
                exp_q.delete();
                active     <= 1'b0;
                pushed_cnt <= 0;
                pop_base   <= pops_total;
            end else begin
                if (ivalid && iready) begin
                    exp_q.push_back(ref_conv(idata));
                    pushed_cnt <= pushed_cnt + 1;
                end
                if (start && !(active && popped != nitems_m)) begin
                    active     <= 1'b1;
                    nitems_m   <= nitems;
                    pushed_cnt <= 0;
                    pop_base   <= pops_total;
                end
            end
        end
    end

    // Output side: checks ovalid and pops/compares each delivered word.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ovalid", ovalid, pushed_cnt != (pops_total - pop_base));
            if (!rst && ovalid && oready) begin
                if (exp_q.size() == 0) begin
                    check("odata_unexpected", 1'b1, 1'b0);
                end else begin
                    check("odata", odata, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                pops_total <= pops_total + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] n);
        nitems = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic push_one(input logic [33:0] w);
        int c = 0;
        idata  = w;
        ivalid = 1'b1;
        @(negedge clk);
        while (!iready && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("push_accepted", iready, 1'b1);
        @(posedge clk);
        #1;
        ivalid = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [31:0] w);
        @(negedge clk);
        check({name, "_valid"}, ovalid, 1'b1);
        check(name, odata, w);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int c = 0; c < budget && !done; c++) tick();
        check(name, done, 1'b1);
    endtask

    // Count handshakes over a fixed number of cycles with ivalid held high.
    task automatic stream_cycles(input int cycles, inout int n);
        for (int c = 0; c < cycles; c++) begin
            idata = rand_word();
            @(negedge clk);
            if (iready) n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_run(input int unsigned n, input int unsigned pv, input int unsigned pr);
        do_start(n);
        for (int c = 0; c < 3000 && !done; c++) begin
            ivalid = ($urandom_range(0, 99) < pv);
            oready = ($urandom_range(0, 99) < pr);
            idata  = rand_word();
            start  = ($urandom_range(0, 15) == 0);
            nitems = $urandom_range(0, 50);
            tick();
        end
        start  = 1'b0;
        ivalid = 1'b0;
        check("random_done", done, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; nitems = '0; ivalid = 1'b0; idata = '0; oready = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        check("reset_iready", iready, 1'b0);
        check("reset_ovalid", ovalid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_odata", odata, 32'h0);
        check("reset_state", dut.state_q, StIdle);
        rst = 1'b0;
        tick();

        // Zero count from IDLE.
        do_start(0);
        check("zero_done", done, 1'b1);
        check("zero_iready", iready, 1'b0);

        // Basic run with one-cycle show-ahead latency.
        oready = 1'b1;
        do_start(4);
        push_one(34'h1_3F80_0000); expect_word("basic0", 32'h3F80_0000);
        push_one(34'h1_C000_0000); expect_word("basic1", 32'hC000_0000);
        push_one(34'h0_8000_0000); expect_word("basic2", 32'h8000_0000);
        push_one(34'h2_0000_0000); expect_word("basic3", 32'h7F80_0000);
        wait_done("basic_done", 5);

        // Exception mapping.
        do_start(2);
        push_one(34'h3_1234_5678); expect_word("exn_nan", 32'h7FC0_0000);
        push_one(34'h2_8000_0000); expect_word("exn_ninf", 32'hFF80_0000);
        wait_done("exn_done", 5);

        // Back-pressure: FIFO fills at 16, then drains all 20 in order.
        do_start(20);
        ivalid = 1'b1; oready = 1'b0; n = 0;
        stream_cycles(30, n);
        check("bp_pushes_to_full", n, 16);
        check("bp_iready_full", iready, 1'b0);
        oready = 1'b1;
        for (int c = 0; c < 100 && !done; c++) stream_cycles(1, n);
        check("bp_total_pushes", n, 20);
        check("bp_done", done, 1'b1);

        // Full boundary: simultaneous push/pop at occupancy 15.
        do_start(30);
        ivalid = 1'b1; oready = 1'b0; n = 0;
        for (int c = 0; c < 40 && n < 15; c++) stream_cycles(1, n);
        check("fb_fill", n, 15);
        oready = 1'b1;
        idata  = rand_word();
        @(negedge clk);
        check("fb_both_handshake", iready && ovalid, 1'b1);
        @(posedge clk);
        #1;
        check("fb_occupancy", dut.u_fifo.count_q, 15);
        for (int c = 0; c < 100 && !done; c++) stream_cycles(1, n);
        check("fb_done", done, 1'b1);

        // Over-supply: only nitems words are taken.
        do_start(3);
        ivalid = 1'b1; oready = 1'b0; n = 0;
        stream_cycles(10, n);
        check("os_pushes", n, 3);
        check("os_iready", iready, 1'b0);
        oready = 1'b1;
        stream_cycles(10, n);
        check("os_total_pushes", n, 3);
        check("os_done", done, 1'b1);
        ivalid = 1'b0;

        // Mid-run reset discards contents.
        do_start(10);
        ivalid = 1'b1; oready = 1'b0; n = 0;
        for (int c = 0; c < 20 && n < 5; c++) stream_cycles(1, n);
        ivalid = 1'b0; oready = 1'b1; n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (ovalid) n++;
            @(posedge clk);
            #1;
        end
        check("mr_pops", n, 2);
        oready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_ovalid", ovalid, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_iready", iready, 1'b0);
        check("mr_state", dut.state_q, StIdle);
        tick();
        check("mr_no_word", ovalid, 1'b0);
        oready = 1'b1;
        do_start(1);
        push_one(34'h1_4049_0FDB); expect_word("mr_after", 32'h4049_0FDB);
        wait_done("mr_after_done", 5);

        // Randomized runs with random throttling and ignored mid-run starts.
        for (int r = 0; r < 6; r++) begin
            random_run($urandom_range(1, 40), $urandom_range(30, 100), $urandom_range(20, 100));
        end

        ivalid = 1'b0;
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
